// File: rtl/mvm_arbiter.sv
`default_nettype none
// ============================================================================
// mvm_arbiter : round-robin share of one mvm unit between forward (0) and
//               backprop (1) requesters, one job at a time.
// Revision    : 1.0
// ============================================================================
module mvm_arbiter #(
    parameter int MATRIX_WIDTH      = 4,
    parameter int MATRIX_HEIGHT     = 5,
    parameter int VECTOR_CELL_WIDTH = 8,
    parameter int MATRIX_CELL_WIDTH = 8,
    parameter int RESULT_CELL_WIDTH = 8,
    parameter int TIMEOUT           = 255,
    localparam int VW = MATRIX_HEIGHT * VECTOR_CELL_WIDTH,
    localparam int MW = MATRIX_WIDTH * MATRIX_HEIGHT * MATRIX_CELL_WIDTH,
    localparam int RW = MATRIX_WIDTH * RESULT_CELL_WIDTH
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [VW-1:0] req0_vector,
    input  logic [MW-1:0] req0_matrix,
    input  logic          req0_valid,
    output logic          req0_ready,
    output logic [RW-1:0] req0_result,
    output logic          req0_result_valid,
    input  logic          req0_result_ready,
    output logic          req0_error,
    input  logic [VW-1:0] req1_vector,
    input  logic [MW-1:0] req1_matrix,
    input  logic          req1_valid,
    output logic          req1_ready,
    output logic [RW-1:0] req1_result,
    output logic          req1_result_valid,
    input  logic          req1_result_ready,
    output logic          req1_error,
    output logic [VW-1:0] mvm_vector,
    output logic          mvm_vector_valid,
    input  logic          mvm_vector_ready,
    output logic [MW-1:0] mvm_matrix,
    output logic          mvm_matrix_valid,
    input  logic          mvm_matrix_ready,
    input  logic [RW-1:0] mvm_result,
    input  logic          mvm_result_valid,
    output logic          mvm_result_ready,
    input  logic          mvm_error,
    output logic          grant,
    output logic          busy,
    output logic          timeout
);

    localparam int CW = $clog2(TIMEOUT) + 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ISSUE  = 2'd1,
        S_WAIT   = 2'd2,
        S_RETURN = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [VW-1:0] vec_q, vec_d;
    logic [MW-1:0] mat_q, mat_d;
    logic [RW-1:0] res_q, res_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
    logic          vdone_q, vdone_d;
    logic          mdone_q, mdone_d;
    logic          grant_q, grant_d;
    logic          last_q, last_d;
    logic          tout_q, tout_d;
    logic          sel;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            vec_q   <= '0;
            mat_q   <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            vdone_q <= 1'b0;
            mdone_q <= 1'b0;
            grant_q <= 1'b0;
            last_q  <= 1'b1;
            tout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            mat_q   <= mat_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            vdone_q <= vdone_d;
            mdone_q <= mdone_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            tout_q  <= tout_d;
        end
    end

    always_comb begin
        state_d           = state_q;
        vec_d             = vec_q;
        mat_d             = mat_q;
        res_d             = res_q;
        cnt_d             = cnt_q;
        err_d             = err_q;
        vdone_d           = vdone_q;
        mdone_d           = mdone_q;
        grant_d           = grant_q;
        last_d            = last_q;
        tout_d            = tout_q;
        req0_ready        = 1'b0;
        req1_ready        = 1'b0;
        mvm_vector_valid  = 1'b0;
        mvm_matrix_valid  = 1'b0;
        mvm_result_ready  = 1'b0;
        req0_result_valid = 1'b0;
        req1_result_valid = 1'b0;
        // Contention goes to whoever was not served last; a lone request wins outright.
        sel = (req0_valid && req1_valid) ? ~last_q : req1_valid;

        case (state_q)
            S_IDLE: begin
                if (req0_valid || req1_valid) begin
                    req0_ready = ~sel;
                    req1_ready = sel;
                    vec_d      = sel ? req1_vector : req0_vector;
                    mat_d      = sel ? req1_matrix : req0_matrix;
                    grant_d    = sel;
                    vdone_d    = 1'b0;
                    mdone_d    = 1'b0;
                    state_d    = S_ISSUE;
                end
            end
            S_ISSUE: begin
                mvm_vector_valid = ~vdone_q;
                mvm_matrix_valid = ~mdone_q;
                if (mvm_vector_valid && mvm_vector_ready) vdone_d = 1'b1;
                if (mvm_matrix_valid && mvm_matrix_ready) mdone_d = 1'b1;
                if (vdone_d && mdone_d) begin
                    cnt_d   = '0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                mvm_result_ready = 1'b1;
                if (mvm_result_valid) begin
                    res_d   = mvm_result;
                    err_d   = mvm_error;
                    state_d = S_RETURN;
                end else if (cnt_q != CW'(TIMEOUT)) begin
                    // The watchdog only flags; the job stays parked in WAIT.
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_d == CW'(TIMEOUT)) tout_d = 1'b1;
                end
            end
            S_RETURN: begin
                req0_result_valid = ~grant_q;
                req1_result_valid = grant_q;
                if (grant_q ? req1_result_ready : req0_result_ready) begin
                    last_d  = grant_q;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign mvm_vector  = vec_q;
    assign mvm_matrix  = mat_q;
    assign req0_result = grant_q ? '0 : res_q;
    assign req1_result = grant_q ? res_q : '0;
    assign req0_error  = req0_result_valid & err_q;
    assign req1_error  = req1_result_valid & err_q;
    assign grant       = grant_q;
    assign busy        = (state_q != S_IDLE);
    assign timeout     = tout_q;

endmodule
`default_nettype wire

// File: tb/tb_mvm_arbiter.sv
`default_nettype none
// tb_mvm_arbiter : table of arbitration jobs scored against a result queue,
// plus hand-written watchdog and asynchronous-reset sequences.
module tb_mvm_arbiter;

    localparam int MWD = 4;
    localparam int MHT = 5;
    localparam int VW  = 40;
    localparam int MW  = 160;
    localparam int RW  = 32;
    localparam int TMO = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [VW-1:0] req0_vector = '0, req1_vector = '0;
    logic [MW-1:0] req0_matrix = '0, req1_matrix = '0;
    logic          req0_valid = 1'b0, req1_valid = 1'b0;
    logic          req0_result_ready = 1'b0, req1_result_ready = 1'b0;
    logic          req0_ready, req1_ready, req0_result_valid, req1_result_valid;
    logic          req0_error, req1_error;
    logic [RW-1:0] req0_result, req1_result;
    logic [VW-1:0] mvm_vector;
    logic [MW-1:0] mvm_matrix;
    logic          mvm_vector_valid, mvm_matrix_valid, mvm_result_ready;
    logic          mvm_vector_ready, mvm_matrix_ready, mvm_result_valid, mvm_error;
    logic [RW-1:0] mvm_result;
    logic          grant, busy, timeout;

    mvm_arbiter #(
        .MATRIX_WIDTH(MWD), .MATRIX_HEIGHT(MHT), .VECTOR_CELL_WIDTH(8),
        .MATRIX_CELL_WIDTH(8), .RESULT_CELL_WIDTH(8), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rst(rst),
        .req0_vector(req0_vector), .req0_matrix(req0_matrix), .req0_valid(req0_valid),
        .req0_ready(req0_ready), .req0_result(req0_result), .req0_result_valid(req0_result_valid),
        .req0_result_ready(req0_result_ready), .req0_error(req0_error),
        .req1_vector(req1_vector), .req1_matrix(req1_matrix), .req1_valid(req1_valid),
        .req1_ready(req1_ready), .req1_result(req1_result), .req1_result_valid(req1_result_valid),
        .req1_result_ready(req1_result_ready), .req1_error(req1_error),
        .mvm_vector(mvm_vector), .mvm_vector_valid(mvm_vector_valid), .mvm_vector_ready(mvm_vector_ready),
        .mvm_matrix(mvm_matrix), .mvm_matrix_valid(mvm_matrix_valid), .mvm_matrix_ready(mvm_matrix_ready),
        .mvm_result(mvm_result), .mvm_result_valid(mvm_result_valid), .mvm_result_ready(mvm_result_ready),
        .mvm_error(mvm_error), .grant(grant), .busy(busy), .timeout(timeout)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference multiply: unsigned cells, result shifted by FRACTION=4 and truncated.
    function automatic logic [RW-1:0] ref_mvm(input logic [VW-1:0] v, input logic [MW-1:0] m);
        logic [RW-1:0] r;
        int            acc;
        r = '0;
        for (int c = 0; c < MWD; c++) begin
            acc = 0;
            for (int k = 0; k < MHT; k++)
                acc += int'(v[k*8 +: 8]) * int'(m[(k*MWD + c)*8 +: 8]);
            r[c*8 +: 8] = 8'(acc >>> 4);
        end
        return r;
    endfunction

    // Behavioural mvm: vector ready after vdelay valid cycles, matrix always ready,
    // error flag taken from bit 7 of vector cell 0.
    logic [VW-1:0] cap_v;
    logic [MW-1:0] cap_m;
    bit            got_v = 0, got_m = 0, hs_pend = 0, mvm_en = 1;
    int            vdelay = 0, vcnt = 0;

    initial begin
        mvm_vector_ready = 1'b0;
        mvm_matrix_ready = 1'b1;
        mvm_result_valid = 1'b0;
        mvm_result       = '0;
        mvm_error        = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                got_v = 0; got_m = 0; hs_pend = 0; vcnt = 0;
                mvm_result_valid = 1'b0;
                mvm_vector_ready = 1'b0;
            end else begin
                if (hs_pend) begin
                    mvm_result_valid = 1'b0;
                    got_v = 0; got_m = 0; hs_pend = 0;
                end
                if (!mvm_vector_valid) vcnt = 0;
                mvm_vector_ready = (vcnt >= vdelay);
                if (mvm_vector_valid) begin
                    if (mvm_vector_ready) begin cap_v = mvm_vector; got_v = 1; end
                    else vcnt++;
                end
                if (mvm_matrix_valid) begin cap_m = mvm_matrix; got_m = 1; end
                if (got_v && got_m && mvm_en && !mvm_result_valid) begin
                    mvm_result       = ref_mvm(cap_v, cap_m);
                    mvm_error        = cap_v[7];
                    mvm_result_valid = 1'b1;
                end
                hs_pend = mvm_result_valid && mvm_result_ready;
            end
        end
    end

    typedef struct {
        bit            v0, v1;
        int            g;
        logic [VW-1:0] vec0, vec1;
        logic [MW-1:0] mat0, mat1;
        int            vdl, hold;
    } job_t;

    typedef struct {
        int            g;
        logic [RW-1:0] res;
        logic          err;
    } exp_t;

    exp_t sbq[$];
    job_t tbl[10];

    function automatic job_t mk(input bit v0, input bit v1, input int g, input int vdl, input int hold);
        job_t j;
        j.v0 = v0; j.v1 = v1; j.g = g; j.vdl = vdl; j.hold = hold;
        for (int i = 0; i < VW/32 + 1; i++) begin
            j.vec0 = {j.vec0[VW-33:0], 32'($urandom)};
            j.vec1 = {j.vec1[VW-33:0], 32'($urandom)};
        end
        for (int i = 0; i < MW/32; i++) begin
            j.mat0 = {j.mat0[MW-33:0], 32'($urandom)};
            j.mat1 = {j.mat1[MW-33:0], 32'($urandom)};
        end
        return j;
    endfunction

    task automatic run_job(input job_t j, input string tag);
        int            n, vv, mv, rr, first;
        exp_t          e;
        bit            ok;
        logic [VW-1:0] wv;
        logic [MW-1:0] wm;
        vdelay      = j.vdl;
        req0_vector = j.vec0; req0_matrix = j.mat0;
        req1_vector = j.vec1; req1_matrix = j.mat1;
        req0_valid  = j.v0;   req1_valid  = j.v1;
        #1;
        n = 0;
        while (!(req0_ready || req1_ready) && n < 50) begin
            @(negedge clk); #1; n++;
        end
        chk({tag, "_accept"}, 64'(req0_ready | req1_ready), 1);
        chk({tag, "_ready_sel"}, {req1_ready, req0_ready}, (j.g != 0) ? 2'b10 : 2'b01);
        wv = (j.g != 0) ? j.vec1 : j.vec0;
        wm = (j.g != 0) ? j.mat1 : j.mat0;
        e.g = j.g; e.res = ref_mvm(wv, wm); e.err = wv[7];
        sbq.push_back(e);
        @(posedge clk); #1;
        if (j.g != 0) req1_valid = 1'b0; else req0_valid = 1'b0;
        chk({tag, "_ready_pulse"}, 64'(req0_ready | req1_ready), 0);
        chk({tag, "_grant"}, 64'(grant), 64'(j.g));
        vv = 0; mv = 0; rr = 0; first = 0; n = 0;
        while (!(req0_result_valid || req1_result_valid) && n < 100) begin
            @(negedge clk); n++;
            vv += int'(mvm_vector_valid);
            mv += int'(mvm_matrix_valid);
            if (mvm_result_ready) begin rr++; if (first == 0) first = n; end
        end
        chk({tag, "_vec_valid_cycles"}, 64'(vv), 64'(j.vdl + 1));
        chk({tag, "_mat_valid_cycles"}, 64'(mv), 1);
        chk({tag, "_wait_entry_cycle"}, 64'(first), 64'(j.vdl + 2));
        if (sbq.size() == 0) begin
            chk({tag, "_scoreboard_empty"}, 1, 0);
            return;
        end
        e = sbq.pop_front();
        chk({tag, "_result_valid"}, {req1_result_valid, req0_result_valid}, (e.g != 0) ? 2'b10 : 2'b01);
        chk({tag, "_result"}, (e.g != 0) ? req1_result : req0_result, e.res);
        chk({tag, "_other_result"}, (e.g != 0) ? req0_result : req1_result, 0);
        chk({tag, "_error"}, {req1_error, req0_error}, (e.g != 0) ? {e.err, 1'b0} : {1'b0, e.err});
        ok = 1;
        for (int h = 0; h < j.hold; h++) begin
            @(negedge clk);
            rr += int'(mvm_result_ready);
            if (((e.g != 0) ? !req1_result_valid : !req0_result_valid) ||
                (((e.g != 0) ? req1_result : req0_result) !== e.res) ||
                req0_ready || req1_ready) ok = 0;
        end
        if (j.hold > 0) chk({tag, "_hold_stable"}, 64'(ok), 1);
        chk({tag, "_mvm_result_ready_cycles"}, 64'(rr), 1);
        if (e.g != 0) req1_result_ready = 1'b1; else req0_result_ready = 1'b1;
        @(posedge clk); #1;
        req0_result_ready = 1'b0;
        req1_result_ready = 1'b0;
        chk({tag, "_result_dropped"}, 64'(req0_result_valid | req1_result_valid), 0);
        chk({tag, "_idle"}, 64'(busy), 0);
    endtask

    initial begin
        int   w;
        job_t j;

        tbl[0] = mk(1, 1, 0, 0, 0);
        tbl[1] = mk(1, 1, 1, 0, 0);
        tbl[2] = mk(1, 1, 0, 0, 0);
        tbl[3] = mk(1, 0, 0, 0, 0);
        for (int k = 0; k < MHT; k++) begin
            tbl[3].vec0[k*8 +: 8] = 8'h10;
            for (int c = 0; c < MWD; c++)
                tbl[3].mat0[(k*MWD + c)*8 +: 8] = (k == c) ? 8'h10 : 8'h00;
        end
        tbl[4] = mk(0, 1, 1, 0, 0);
        tbl[4].vec1[7:0] = 8'h93;
        tbl[5] = mk(0, 1, 1, 0, 0);
        tbl[5].vec1[7:0] = 8'h21;
        tbl[6] = mk(1, 0, 0, 3, 0);
        tbl[7] = mk(0, 1, 1, 0, 0);
        tbl[8] = mk(1, 1, 0, 0, 10);
        tbl[9] = mk(1, 1, 1, 0, 0);

        #3;
        chk("reset_outputs",
            {req0_ready, req1_ready, req0_result_valid, req1_result_valid, req0_error, req1_error,
             mvm_vector_valid, mvm_matrix_valid, mvm_result_ready, grant, busy, timeout}, 0);
        chk("reset_buffers", 64'(|{mvm_vector, mvm_matrix, req0_result, req1_result}), 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk); #1;

        for (int i = 0; i < 10; i++) run_job(tbl[i], $sformatf("job%0d", i));
        chk("identity_result", tbl[3].vec0[7:0] == 8'h10 ? ref_mvm(tbl[3].vec0, tbl[3].mat0) : '0, 32'h10101010);

        // Watchdog: the mvm never answers.
        req0_valid = 1'b0; req1_valid = 1'b0;
        mvm_en = 0; vdelay = 0;
        req0_vector = tbl[0].vec0; req0_matrix = tbl[0].mat0;
        req0_valid = 1'b1;
        #1;
        w = 0;
        while (!req0_ready && w < 20) begin @(negedge clk); #1; w++; end
        chk("tmo_accept", 64'(req0_ready), 1);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        w = 0;
        for (int n = 0; n < 60 && w < TMO + 1; n++) begin
            @(negedge clk);
            if (mvm_result_ready) begin
                w++;
                if (w == TMO)     chk("tmo_low_before", 64'(timeout), 0);
                if (w == TMO + 1) chk("tmo_rise", 64'(timeout), 1);
            end
        end
        chk("tmo_wait_cycles_seen", 64'(w), 64'(TMO + 1));
        repeat (20) @(negedge clk);
        chk("tmo_sticky_state", {timeout, busy, mvm_result_ready}, 3'b111);

        #2 rst = 1'b0;
        mvm_en = 1;
        #1 chk("tmo_cleared_by_rst", {timeout, busy}, 2'b00);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk); #1;

        // Asynchronous reset between edges while a job sits in ISSUE.
        vdelay = 8;
        req1_vector = tbl[1].vec1; req1_matrix = tbl[1].mat1;
        req1_valid = 1'b1;
        #1;
        w = 0;
        while (!req1_ready && w < 20) begin @(negedge clk); #1; w++; end
        chk("rst_job_accept", 64'(req1_ready), 1);
        @(posedge clk); #1;
        req1_valid = 1'b0;
        @(negedge clk);
        chk("rst_job_in_issue", {busy, mvm_vector_valid, grant}, 3'b111);
        #2 rst = 1'b0;
        #1;
        chk("async_rst_outputs",
            {req0_ready, req1_ready, req0_result_valid, req1_result_valid, req0_error, req1_error,
             mvm_vector_valid, mvm_matrix_valid, mvm_result_ready, grant, busy, timeout}, 0);
        chk("async_rst_buffers", 64'(|{mvm_vector, mvm_matrix, req0_result, req1_result}), 0);
        @(negedge clk);
        rst = 1'b1;
        vdelay = 0;
        @(negedge clk); #1;
        j = mk(1, 1, 0, 0, 0);
        run_job(j, "post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1);
    end

endmodule
`default_nettype wire
